// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_pkg
// Brief    : Shared types and constants for the piso_tx serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int c_LSB_FIRST = 0;
  localparam int c_MSB_FIRST = 1;

  // Bit-counter width; at least one bit so WIDTH=2 still has a counter.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_if
// Brief    : Word handshake and serial-output bundle of the piso_tx block.
// Revision : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  import piso_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             hold;
  logic             ser_d;
  logic             ser_en;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, ser_d, ser_en, busy, done
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, ser_d, ser_en, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/piso_tx_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : tx_hold_buf
// Brief    : One-entry holding buffer in front of the piso_tx shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tx_hold_buf
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             take,
  output logic             in_ready,
  output logic [WIDTH-1:0] buf_data,
  output logic             buf_full
);

  logic             r_buf_full;
  logic [WIDTH-1:0] r_buf_data;
  logic             w_accept;

  // Accept and take are mutually exclusive: accept needs empty, take needs full.
  assign w_accept = in_valid & ~r_buf_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
    end else if (take) begin
      r_buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_data <= in_data;
    end
  end

  assign in_ready = ~r_buf_full;
  assign buf_data = r_buf_data;
  assign buf_full = r_buf_full;

endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Brief    : Bit-serial transmitter with data bit plus per-bit enable strobe.
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = c_LSB_FIRST
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave bus
);

  localparam int         c_CNT_W    = cnt_w(WIDTH);
  localparam logic [0:0] c_ST_IDLE  = S_IDLE;
  localparam logic [0:0] c_ST_SHIFT = S_SHIFT;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   w_buf_data;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_buf_full;
  logic               w_ser_d;
  logic               w_shifting;
  logic               w_last;
  logic               w_take;

  tx_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .take     (w_take),
    .in_ready (bus.in_ready),
    .buf_data (w_buf_data),
    .buf_full (w_buf_full)
  );

  generate
    if (MSB_FIRST == c_MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      assign w_ser_d   = r_shreg[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      assign w_ser_d   = r_shreg[0];
    end
  endgenerate

  assign w_shifting = (r_state == c_ST_SHIFT) & ~bus.hold;
  assign w_last     = (r_cnt == c_LAST);
  // A buffered word moves into the shifter from IDLE or on an un-held last bit.
  assign w_take     = w_buf_full & (((r_state == c_ST_IDLE)) | (w_shifting & w_last));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_buf_full) begin
            r_shreg <= w_buf_data;
            r_cnt   <= '0;
            r_state <= c_ST_SHIFT;
          end
        end
        c_ST_SHIFT: begin
          if (!bus.hold) begin
            if (!w_last) begin
              r_shreg <= w_shifted;
              r_cnt   <= r_cnt + 1'b1;
            end else if (w_buf_full) begin
              r_shreg <= w_buf_data;
              r_cnt   <= '0;
            end else begin
              r_state <= c_ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ser_d  = w_ser_d;
  assign bus.ser_en = w_shifting;
  assign bus.done   = w_shifting & w_last;
  assign bus.busy   = (r_state == c_ST_SHIFT) | w_buf_full;

endmodule
`default_nettype wire
